// File: rtl/mem_stage_pkg.sv
// Shared types for the RV32I memory-access stage: pipeline words, memory funct3
// encodings and the MEM-stage FSM states.
package mem_stage_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT_RSP
  } mem_state_e;

  // Stores reuse the load encodings for size, so SB/SH/SW alias LB/LH/LW.
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } funct3_mem_e;

  localparam funct3_mem_e SB = LB;
  localparam funct3_mem_e SH = LH;
  localparam funct3_mem_e SW = LW;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       reg_write;
    logic       mem_to_reg;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           rs2_data_str;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    ex_mem_ctrl_t              ctrl;
    logic                      valid_ex_mem;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           load_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      valid_mem_wb;
  } mem_wb_reg_t;

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Combinational byte-lane steering for stores and alignment/extension for loads.
module mem_stage_load_store_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]      addr,
  input  logic [2:0]      size,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'b0, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'b0, h};
  endfunction

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rdata[{addr, 3'b000} +: 8];
  assign ld_half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata      = rs2;
    misaligned = 1'b0;
    unique case (size[1:0])
      2'b00: begin
        be    = 4'b0001 << addr;
        wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{rs2[15:0]}};
        misaligned = addr[0];
      end
      default: misaligned = |addr;
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (size)
      LB:      load_data = ext8(ld_byte, 1'b1);
      LBU:     load_data = ext8(ld_byte, 1'b0);
      LH:      load_data = ext16(ld_half, 1'b1);
      LHU:     load_data = ext16(ld_half, 1'b0);
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: single-outstanding data-memory port, stall control,
// forwarding tap and the registered MEM/WB pipeline word.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  ex_mem_reg_t               ex_mem_in,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic [XLEN-1:0]           dmem_addr,
  output logic                      dmem_we,
  output logic [3:0]                dmem_be,
  output logic [XLEN-1:0]           dmem_wdata,
  input  logic                      dmem_rsp_valid,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic [XLEN-1:0]           mem_alu_result,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                      mem_reg_write,
  output mem_wb_reg_t               mem_wb_out,
  output logic                      mem_stall,
  output logic                      misaligned_fault,
  output logic                      bus_error
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_e      state;
  logic [15:0]     tmo_cnt;
  logic [1:0]      ld_off_p1;
  logic [2:0]      ld_size_p1;

  logic            memop, is_store, in_wait;
  logic            issue_idle, handshake, st_done, ld_done, tmo_hit;
  logic [1:0]      al_off;
  logic [2:0]      al_size;
  logic [XLEN-1:0] al_load;
  logic            al_misaligned;

  assign memop    = ex_mem_in.valid_ex_mem & (ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write);
  assign is_store = ex_mem_in.ctrl.mem_write;
  assign in_wait  = (state == MEM_WAIT_RSP);

  // Once the request is accepted the load is extracted with the offset/size captured then.
  assign al_off  = in_wait ? ld_off_p1  : ex_mem_in.alu_result[1:0];
  assign al_size = in_wait ? ld_size_p1 : ex_mem_in.ctrl.mem_size;

  mem_stage_load_store_align u_align (
    .addr       (al_off),
    .size       (al_size),
    .rs2        (ex_mem_in.rs2_data_str),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  assign issue_idle     = (state == MEM_IDLE) & memop & ~al_misaligned;
  assign dmem_req_valid = issue_idle | (state == MEM_REQ);
  assign dmem_addr      = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};
  assign dmem_we        = is_store;

  assign handshake = dmem_req_valid & dmem_req_ready;
  assign st_done   = handshake & is_store;
  assign ld_done   = in_wait & dmem_rsp_valid;
  assign tmo_hit   = in_wait & ~dmem_rsp_valid & (tmo_cnt == TMO_LAST);

  // A timed-out load also releases the stall so the faulting instruction drains.
  assign mem_stall = (dmem_req_valid & ~st_done) | (in_wait & ~dmem_rsp_valid & ~tmo_hit);

  assign mem_alu_result = ex_mem_in.alu_result;
  assign mem_rd_addr    = ex_mem_in.rd_addr;
  assign mem_reg_write  = ex_mem_in.ctrl.reg_write & ex_mem_in.valid_ex_mem & ~ex_mem_in.ctrl.mem_read;

  // Stage boundary: control state, fault pulses and the MEM/WB word
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= MEM_IDLE;
      tmo_cnt          <= '0;
      mem_wb_out       <= '0;
      misaligned_fault <= 1'b0;
      bus_error        <= 1'b0;
    end else begin
      misaligned_fault <= (state == MEM_IDLE) & memop & al_misaligned;
      bus_error        <= tmo_hit;
      tmo_cnt          <= (in_wait & ~dmem_rsp_valid & ~tmo_hit) ? tmo_cnt + 16'd1 : 16'd0;

      unique case (state)
        MEM_IDLE: begin
          if (issue_idle & ~dmem_req_ready) state <= MEM_REQ;
          else if (handshake & ~is_store)   state <= MEM_WAIT_RSP;
        end
        MEM_REQ: begin
          if (dmem_req_ready) state <= is_store ? MEM_IDLE : MEM_WAIT_RSP;
        end
        MEM_WAIT_RSP: begin
          if (dmem_rsp_valid | tmo_hit) state <= MEM_IDLE;
        end
        default: state <= MEM_IDLE;
      endcase

      if (mem_stall) begin
        mem_wb_out.valid_mem_wb <= 1'b0;
      end else begin
        mem_wb_out.alu_result   <= ex_mem_in.alu_result;
        mem_wb_out.load_data    <= ld_done ? al_load : '0;
        mem_wb_out.rd_addr      <= ex_mem_in.rd_addr;
        mem_wb_out.reg_write    <= ex_mem_in.ctrl.reg_write;
        mem_wb_out.mem_to_reg   <= ex_mem_in.ctrl.mem_to_reg;
        mem_wb_out.valid_mem_wb <= st_done | ld_done | (ex_mem_in.valid_ex_mem & ~memop);
      end
    end
  end

  // Stage boundary: load offset/size captured at request acceptance
  always_ff @(posedge clk) begin
    if (handshake) begin
      ld_off_p1  <= ex_mem_in.alu_result[1:0];
      ld_size_p1 <= ex_mem_in.ctrl.mem_size;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage; the bench plays both the upstream
// pipeline and the data memory and predicts every output from transaction-level rules.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int T = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  ex_mem_reg_t               ex_mem_in;
  logic                      dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [XLEN-1:0]           dmem_addr, dmem_wdata, dmem_rdata, mem_alu_result;
  logic [3:0]                dmem_be;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
  logic                      mem_reg_write, mem_stall, misaligned_fault, bus_error;
  mem_wb_reg_t               mem_wb_out;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;

  // Expected values of the registered outputs for the current cycle
  logic        e_valid, e_isld, e_rw, e_m2r, e_mis, e_berr;
  logic [31:0] e_alu, e_ld;
  logic [4:0]  e_rd;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ex_mem_in(ex_mem_in),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .mem_alu_result(mem_alu_result), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_wb_out(mem_wb_out), .mem_stall(mem_stall),
    .misaligned_fault(misaligned_fault), .bus_error(bus_error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference rules ----
  function automatic bit m_aligned(input logic [2:0] sz, input logic [1:0] off);
    if (sz[1:0] == 2'd0) return 1'b1;
    if (sz[1:0] == 2'd1) return (off % 2) == 0;
    return off == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] off);
    int b;
    b = 0;
    for (int k = 0; k < 4; k++) begin
      if (sz[1:0] == 2'd0 && k == off) b += (1 << k);
      if (sz[1:0] == 2'd1 && k / 2 == off / 2) b += (1 << k);
      if (sz[1:0] == 2'd2) b += (1 << k);
    end
    return 4'(b);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] rs2);
    if (sz[1:0] == 2'd0) return (rs2 & 32'hFF) * 32'h01010101;
    if (sz[1:0] == 2'd1) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] off, input logic [31:0] w);
    longint u, v;
    if (sz == 3'd2) return w;
    if (sz[1:0] == 2'd0) u = (longint'(w) >> (8 * off)) % 256;
    else                 u = (longint'(w) >> (16 * (off / 2))) % 65536;
    v = u;
    if (sz == 3'd0 && u >= 128)   v = u - 256;
    if (sz == 3'd1 && u >= 32768) v = u - 65536;
    return 32'(v);
  endfunction

  function automatic ex_mem_reg_t mk(input logic v, input logic rd, input logic wr, input logic [2:0] sz,
                                     input logic rw, input logic [31:0] alu, input logic [31:0] rs2,
                                     input logic [4:0] rda);
    ex_mem_reg_t r;
    r = '0;
    r.valid_ex_mem = v;  r.ctrl.mem_read = rd; r.ctrl.mem_write = wr;
    r.ctrl.mem_size = sz; r.ctrl.reg_write = rw; r.ctrl.mem_to_reg = rd;
    r.alu_result = alu;  r.rs2_data_str = rs2;  r.rd_addr = rda;
    return r;
  endfunction

  // One clock cycle: check everything at negedge, then advance registered expectations.
  task automatic cycle(input logic x_req, input logic x_stall, input logic n_valid, input logic n_isld,
                       input logic [31:0] n_ld, input logic n_mis, input logic n_berr);
    @(negedge clk);
    chk("req_valid", {31'b0, dmem_req_valid}, {31'b0, x_req});
    if (x_req) begin
      chk("addr", dmem_addr, ex_mem_in.alu_result & 32'hFFFF_FFFC);
      chk("we", {31'b0, dmem_we}, {31'b0, ex_mem_in.ctrl.mem_write});
      if (ex_mem_in.ctrl.mem_write) begin
        chk("be", {28'b0, dmem_be}, {28'b0, m_be(ex_mem_in.ctrl.mem_size, ex_mem_in.alu_result[1:0])});
        chk("wdata", dmem_wdata, m_wdata(ex_mem_in.ctrl.mem_size, ex_mem_in.rs2_data_str));
      end
    end
    chk("stall", {31'b0, mem_stall}, {31'b0, x_stall});
    if (mem_stall) stall_cnt++;
    chk("fwd_alu", mem_alu_result, ex_mem_in.alu_result);
    chk("fwd_rd", {27'b0, mem_rd_addr}, {27'b0, ex_mem_in.rd_addr});
    chk("fwd_rw", {31'b0, mem_reg_write},
        {31'b0, ex_mem_in.ctrl.reg_write && ex_mem_in.valid_ex_mem && !ex_mem_in.ctrl.mem_read});
    chk("wb_valid", {31'b0, mem_wb_out.valid_mem_wb}, {31'b0, e_valid});
    if (e_valid) begin
      chk("wb_alu", mem_wb_out.alu_result, e_alu);
      chk("wb_rd", {27'b0, mem_wb_out.rd_addr}, {27'b0, e_rd});
      chk("wb_rw", {31'b0, mem_wb_out.reg_write}, {31'b0, e_rw});
      chk("wb_m2r", {31'b0, mem_wb_out.mem_to_reg}, {31'b0, e_m2r});
      if (e_isld) chk("wb_load", mem_wb_out.load_data, e_ld);
    end
    chk("mis_fault", {31'b0, misaligned_fault}, {31'b0, e_mis});
    chk("bus_error", {31'b0, bus_error}, {31'b0, e_berr});
    @(posedge clk);
    #1;
    e_valid = n_valid; e_isld = n_isld; e_ld = n_ld; e_mis = n_mis; e_berr = n_berr;
    e_alu = ex_mem_in.alu_result; e_rd = ex_mem_in.rd_addr;
    e_rw = ex_mem_in.ctrl.reg_write; e_m2r = ex_mem_in.ctrl.mem_to_reg;
  endtask

  // d_r: cycles before req_ready; d_s: WAIT cycle carrying rsp_valid (> T means none).
  task automatic run_instr(input ex_mem_reg_t ins, input int d_r, input int d_s, input logic [31:0] rdat);
    bit memop, st, done;
    ex_mem_in = ins;
    memop = ins.valid_ex_mem && (ins.ctrl.mem_read || ins.ctrl.mem_write);
    st    = ins.ctrl.mem_write;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
    if (!memop) begin
      dmem_rsp_valid = 1'b1;  // stale response must be ignored
      cycle(0, 0, ins.valid_ex_mem, 0, 0, 0, 0);
    end else if (!m_aligned(ins.ctrl.mem_size, ins.alu_result[1:0])) begin
      dmem_req_ready = 1'($urandom_range(0, 1));
      dmem_rsp_valid = 1'($urandom_range(0, 1));
      cycle(0, 0, 0, 0, 0, 1, 0);
    end else begin
      for (int c = 0; c <= d_r; c++) begin
        dmem_req_ready = (c == d_r);
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        dmem_rdata     = $urandom;
        if (st && c == d_r) cycle(1, 0, 1, 0, 0, 0, 0);
        else                cycle(1, 1, 0, 0, 0, 0, 0);
      end
      done = !st;
      for (int w = 1; w <= T && done; w++) begin
        dmem_req_ready = 1'($urandom_range(0, 1));
        dmem_rsp_valid = (w == d_s);
        dmem_rdata     = (w == d_s) ? rdat : $urandom;
        if (w == d_s) begin
          cycle(0, 0, 1, 1, m_load(ins.ctrl.mem_size, ins.alu_result[1:0], rdat), 0, 0);
          done = 0;
        end else if (w == T) cycle(0, 0, 0, 0, 0, 0, 1);
        else                 cycle(0, 1, 0, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ex_mem_in = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = $urandom;
    @(posedge clk); #1;
    reset = 1'b0;
    {e_valid, e_isld, e_rw, e_m2r, e_mis, e_berr} = '0;
    e_alu = '0; e_ld = '0; e_rd = '0;
  endtask

  initial begin
    ex_mem_reg_t ins;
    int s0;
    logic [2:0] sz;
    logic [2:0] lsz [5];
    lsz = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    // Hand-computed pins on the reference rules
    chk("pin_be_sb", {28'b0, m_be(3'd0, 2'd3)}, 32'h8);
    chk("pin_be_sh", {28'b0, m_be(3'd1, 2'd2)}, 32'hC);
    chk("pin_wd_sb", m_wdata(3'd0, 32'h0000_00AB), 32'hABAB_ABAB);
    chk("pin_lh",    m_load(3'd1, 2'd2, 32'h8001_7FFF), 32'hFFFF_8001);
    chk("pin_lhu",   m_load(3'd5, 2'd2, 32'h8001_7FFF), 32'h0000_8001);
    chk("pin_lb",    m_load(3'd0, 2'd1, 32'h0000_8000), 32'hFFFF_FF80);

    reset = 1'b1;
    ex_mem_in = '0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    apply_reset();
    chk("rst_wb_zero", {31'b0, |mem_wb_out}, 32'h0);

    // ALU op
    s0 = stall_cnt;
    run_instr(mk(1, 0, 0, 3'd0, 1, 32'h1234, 32'h0, 5'd5), 0, 1, 0);
    chk("alu_valid", {31'b0, mem_wb_out.valid_mem_wb}, 32'h1);
    chk("alu_result", mem_wb_out.alu_result, 32'h1234);
    chk("alu_stall", stall_cnt - s0, 0);

    // SB with immediate ready
    s0 = stall_cnt;
    run_instr(mk(1, 0, 1, 3'd0, 0, 32'h1003, 32'hAB, 5'd0), 0, 1, 0);
    chk("sb_stall", stall_cnt - s0, 0);

    // LH / LHU with delayed ready and response
    s0 = stall_cnt;
    run_instr(mk(1, 1, 0, 3'd1, 1, 32'h2002, 32'h0, 5'd7), 2, 3, 32'h8001_7FFF);
    chk("lh_stall", stall_cnt - s0, 5);
    chk("lh_data", mem_wb_out.load_data, 32'hFFFF_8001);
    run_instr(mk(1, 1, 0, 3'd5, 1, 32'h2002, 32'h0, 5'd7), 2, 3, 32'h8001_7FFF);
    chk("lhu_data", mem_wb_out.load_data, 32'h0000_8001);

    // Misaligned LW
    run_instr(mk(1, 1, 0, 3'd2, 1, 32'h2001, 32'h0, 5'd3), 0, 1, 0);
    chk("mis_pulse", {31'b0, misaligned_fault}, 32'h1);
    chk("mis_bubble", {31'b0, mem_wb_out.valid_mem_wb}, 32'h0);

    // LW timeout, then a late response with nothing outstanding
    s0 = stall_cnt;
    run_instr(mk(1, 1, 0, 3'd2, 1, 32'h3000, 32'h0, 5'd9), 0, T + 1, 0);
    chk("tmo_pulse", {31'b0, bus_error}, 32'h1);
    chk("tmo_stall", stall_cnt - s0, T);
    run_instr(mk(0, 0, 0, 3'd0, 0, 32'h0, 32'h0, 5'd0), 0, 1, 0);

    // Reset while waiting for a load response
    ex_mem_in = mk(1, 1, 0, 3'd2, 1, 32'h4000, 32'h0, 5'd4);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    cycle(1, 1, 0, 0, 0, 0, 0);
    dmem_req_ready = 1'b0;
    cycle(0, 1, 0, 0, 0, 0, 0);
    apply_reset();
    chk("rst_mid_req", {31'b0, dmem_req_valid}, 32'h0);
    chk("rst_mid_stall", {31'b0, mem_stall}, 32'h0);
    repeat (3) run_instr(mk(0, 1, 0, 3'd2, 1, 32'h4000, 32'h0, 5'd4), 0, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = $urandom;
      if (kind < 2) begin
        ins = mk(1, 0, 0, 3'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
      end else if (kind < 3) begin
        ins = mk(0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
      end else if (kind < 7) begin
        sz = lsz[$urandom_range(0, 4)];
        ins = mk(1, 1, 0, sz, 1, a, $urandom, 5'($urandom));
      end else begin
        sz = 3'($urandom_range(0, 2));
        ins = mk(1, 0, 1, sz, 0, a, $urandom, 5'($urandom));
      end
      run_instr(ins, $urandom_range(0, 3), $urandom_range(1, T + 1), $urandom);
    end
    run_instr(mk(0, 0, 0, 3'd0, 0, 32'h0, 32'h0, 5'd0), 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. Consumes ex_mem_reg_t from the execute stage and produces the registered MEM/WB pipeline word.
- Drives a single-outstanding valid/ready data-memory port. Performs store byte-lane steering and load alignment/extension.
- Stalls the upstream pipeline while an access is in flight.
- Exports the forwarding tap (alu_result, rd, reg_write) consumed by the execute stage.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in WAIT_RSP before bus_error is raised; range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_mem_in  in  ex_mem_reg_t  execute result: alu_result, rs2_data_str, rd_addr, ctrl (mem_read, mem_write, mem_size[2:0]=funct3, reg_write, mem_to_reg), valid_ex_mem
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  XLEN  word-aligned address ({alu_result[31:2],2'b00})
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  XLEN  load word
- mem_alu_result  out  XLEN  forwarding tap = ex_mem_in.alu_result
- mem_rd_addr  out  REG_ADDR_WIDTH  forwarding tap = ex_mem_in.rd_addr
- mem_reg_write  out  1  forwarding tap = ctrl.reg_write & valid_ex_mem & ~ctrl.mem_read
- mem_wb_out  out  mem_wb_reg_t  registered: alu_result, load_data, rd_addr, reg_write, mem_to_reg, valid_mem_wb
- mem_stall  out  1  hold EX/MEM and all upstream stages
- misaligned_fault  out  1  one-cycle pulse on a misaligned access
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset:
  - state=IDLE, timeout counter=0.
  - mem_wb_out all zero (valid_mem_wb=0).
  - dmem_req_valid=0, mem_stall=0, misaligned_fault=0, bus_error=0.
- Memory op (memop) = valid_ex_mem & (mem_read | mem_write).
- Alignment:
  - LW/SW require addr[1:0]=0.
  - LH/LHU/SH require addr[0]=0.
  - Byte accesses are always aligned.
- Misaligned memop in IDLE:
  - No request is issued.
  - misaligned_fault pulses.
  - Next mem_wb_out is a bubble (valid=0).
  - No stall.
- Non-memop valid instruction: registered into mem_wb_out on the next edge; 1-cycle latency, no stall.
- FSM states and transitions:
  - IDLE: aligned memop → dmem_req_valid=1 combinationally in the same cycle.
    - req_ready=1 & store → complete this cycle; stay IDLE.
    - req_ready=1 & load → WAIT_RSP.
    - req_ready=0 → REQ.
  - REQ: hold dmem_req_valid and all request fields stable until req_ready.
    - Then: store → IDLE (complete); load → WAIT_RSP.
  - WAIT_RSP: dmem_req_valid=0; timeout counter increments each cycle.
    - rsp_valid → latch extended data into mem_wb_out; IDLE.
    - Counter reaches TIMEOUT_CYCLES → bus_error pulse; mem_wb_out bubble; IDLE.
- mem_stall = memop & aligned & ~(completing this cycle). Completing means a store handshake, or rsp_valid in WAIT_RSP.
- mem_wb_out updates only on a completion edge or a non-stalled edge. While stalled, valid_mem_wb=0 is written (bubble into WB).
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111.
- Load extract uses the captured addr[1:0]:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- rsp_valid in IDLE or REQ is ignored (stale response after reset or timeout).
- Simultaneous req_ready and rsp_valid in IDLE: request handled; rsp ignored.
- Reset mid-operation: abandon the access; state→IDLE, no write-back.
- Invalid instruction (valid_ex_mem=0) never issues a request, regardless of ctrl bits.

Decomposition:
- riscv_pkg additions:
  - mem_state_e {MEM_IDLE, MEM_REQ, MEM_WAIT_RSP}
  - funct3_mem_e {LB, LH, LW, LBU, LHU, SB=0, SH=1, SW=2}
  - mem_wb_reg_t
  - ctrl.mem_size field
- Sub-module load_store_align (combinational):
  - Inputs: addr[1:0], size, rs2, rdata.
  - Outputs: be, wdata, load_data, misaligned.
  - Instanced once; FSM and registers stay in mem_stage.

Test Plan:
- ALU op, rd=x5, alu_result=0x1234, no memop → next cycle mem_wb_out.valid=1, alu_result=0x1234, mem_stall never 1.
- SB addr 0x1003, rs2=0xAB, req_ready=1 immediately → same cycle dmem_be=4'b1000, wdata=0xABABABAB, dmem_addr=0x1000, no stall.
- LH addr 0x2002, req_ready after 2 cycles, rsp_valid 3 cycles later with rdata=0x8001_7FFF → mem_stall high 5 cycles, load_data=0xFFFF8001; LHU same → 0x00008001.
- LW addr 0x2001 → misaligned_fault pulse, dmem_req_valid stays 0, valid_mem_wb=0.
- LW with no response, TIMEOUT_CYCLES=4 → bus_error after 4 WAIT_RSP cycles, stall released, late rsp_valid ignored.
- Reset asserted in WAIT_RSP → next cycle IDLE, all outputs at reset values; following rsp_valid produces no write-back.
